frame_buffer_port_arbiter: RTL and testbench



---
 rtl/fb_arb_pkg.sv | 16 +
 rtl/frame_buffer_port_arbiter_if.sv | 45 ++++
 rtl/fb_arb_valid_pipe.sv | 35 +++
 rtl/frame_buffer_port_arbiter.sv | 95 +++++++++
 tb/tb_frame_buffer_port_arbiter.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fb_arb_pkg.sv
// -----------------------------------------------------------------------------
// fb_arb_pkg
// Shared definitions for the frame-buffer port arbiter: the owner encoding
// (who holds BRAM port 0 this cycle) and its width.
// -----------------------------------------------------------------------------
package fb_arb_pkg;

    localparam int OWNER_W = 2;

    typedef enum logic [OWNER_W-1:0] {
        OWNER_IDLE = 2'd0,
        OWNER_WR   = 2'd1,
        OWNER_RD   = 2'd2
    } owner_e;

endpackage : fb_arb_pkg

// File: rtl/frame_buffer_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// frame_buffer_port_arbiter_if
// Bundles the requester handshakes and the BRAM port 0 signals of the
// frame-buffer arbiter.
//   slave  : the arbiter's view (takes requests and read data, drives grants,
//            read valid/data, BRAM controls and the debug owner).
//   master : the surrounding controllers and memory.
// -----------------------------------------------------------------------------
interface frame_buffer_port_arbiter_if
    import fb_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 16
);
    // Write requester (camera FIFO drain)
    logic                  wr_req;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_gnt;
    // Read requester (HDMI FIFO fill)
    logic                  rd_req;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_urgent;
    logic                  rd_gnt;
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] rd_data;
    // BRAM port 0
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    // Debug
    logic [OWNER_W-1:0]    owner;

    modport slave (
        input  wr_req, wr_addr, wr_data, rd_req, rd_addr, rd_urgent, mem_rdata,
        output wr_gnt, rd_gnt, rd_valid, rd_data, mem_we, mem_addr, mem_wdata, owner
    );

    modport master (
        output wr_req, wr_addr, wr_data, rd_req, rd_addr, rd_urgent, mem_rdata,
        input  wr_gnt, rd_gnt, rd_valid, rd_data, mem_we, mem_addr, mem_wdata, owner
    );

endinterface : frame_buffer_port_arbiter_if

// File: rtl/fb_arb_valid_pipe.sv
// -----------------------------------------------------------------------------
// fb_arb_valid_pipe
// Delays the read-grant strobe by RD_LATENCY cycles so that it lines up with
// the BRAM read data. Cleared asynchronously, so reads in flight at reset
// never produce a valid.
//   clk_i    : clock
//   resetn_i : asynchronous active-low clear
//   strb_i   : read issued this cycle
//   strb_o   : strobe delayed by RD_LATENCY cycles (RD_LATENCY >= 1)
// -----------------------------------------------------------------------------
module fb_arb_valid_pipe #(
    parameter int RD_LATENCY = 1
) (
    input  logic clk_i,
    input  logic resetn_i,
    input  logic strb_i,
    output logic strb_o
);

    logic [RD_LATENCY-1:0] pipe_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values; the delay line is control state, so it is
    // reset to guarantee no stale valid escapes after reset.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= (pipe_q << 1) | RD_LATENCY'(strb_i);
        end
    end

    assign strb_o = pipe_q[RD_LATENCY-1];

endmodule : fb_arb_valid_pipe

// File: rtl/frame_buffer_port_arbiter.sv
// -----------------------------------------------------------------------------
// frame_buffer_port_arbiter
// Shares BRAM port 0 between the write controller (camera FIFO drain) and the
// read controller (HDMI FIFO fill). Burst-limited round robin: a requester may
// keep the port for at most BURST_MAX consecutive grants while the other one
// waits. An urgent reader may preempt a write burst, but cannot block the
// writer once the read burst hits the limit.
//   clk_i, resetn_i : clock, asynchronous active-low reset
//   bus (slave)     : requests/grants, read valid/data, BRAM controls, owner
// Grants are combinational from the requests and the registered owner/burst
// count; read valid is the read grant delayed by RD_LATENCY.
// -----------------------------------------------------------------------------
module frame_buffer_port_arbiter
    import fb_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 16,
    parameter int BURST_MAX  = 16,   // >= 1
    parameter int RD_LATENCY = 1     // >= 1
) (
    input  logic                        clk_i,
    input  logic                        resetn_i,
    frame_buffer_port_arbiter_if.slave  bus
);

    localparam int               CNT_W   = $clog2(BURST_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_MAX);

    owner_e           owner_q;
    owner_e           sel;
    logic [CNT_W-1:0] burst_q;
    logic [CNT_W-1:0] burst_d;
    logic             at_limit;

    assign at_limit = (burst_q == CNT_MAX);

    // NOTE: every signal driven here gets a default first, so no path through
    // the branches can leave it unassigned and infer a latch.
    always_comb begin
        sel     = OWNER_IDLE;
        burst_d = '0;

        if (bus.wr_req && bus.rd_req) begin
            unique case (owner_q)
                // Urgency may cut a write burst short; the limit hands over.
                OWNER_WR: sel = (bus.rd_urgent || at_limit) ? OWNER_RD : OWNER_WR;
                // Urgency never blocks the writer once the read burst is spent.
                OWNER_RD: sel = at_limit ? OWNER_WR : OWNER_RD;
                default:  sel = bus.rd_urgent ? OWNER_RD : OWNER_WR;
            endcase
        end else if (bus.wr_req) begin
            sel = OWNER_WR;
        end else if (bus.rd_req) begin
            sel = OWNER_RD;
        end

        if (sel == OWNER_IDLE) begin
            burst_d = '0;
        end else if (sel == owner_q) begin
            burst_d = at_limit ? burst_q : burst_q + 1'b1;
        end else begin
            burst_d = CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            owner_q <= OWNER_IDLE;
            burst_q <= '0;
        end else begin
            owner_q <= sel;
            burst_q <= burst_d;
        end
    end

    // Grants are gated by reset so nothing reaches the BRAM or pops the
    // camera FIFO while the block is held in reset.
    assign bus.wr_gnt    = (sel == OWNER_WR) && resetn_i;
    assign bus.rd_gnt    = (sel == OWNER_RD) && resetn_i;
    assign bus.mem_we    = bus.wr_gnt;
    assign bus.mem_addr  = (sel == OWNER_WR) ? bus.wr_addr : bus.rd_addr;
    assign bus.mem_wdata = bus.wr_data;
    assign bus.rd_data   = bus.mem_rdata;
    assign bus.owner     = owner_q;

    fb_arb_valid_pipe #(
        .RD_LATENCY (RD_LATENCY)
    ) u_valid_pipe (
        .clk_i    (clk_i),
        .resetn_i (resetn_i),
        .strb_i   (bus.rd_gnt),
        .strb_o   (bus.rd_valid)
    );

endmodule : frame_buffer_port_arbiter

// File: tb/tb_frame_buffer_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_frame_buffer_port_arbiter
// Directed scoreboard bench. dut1 (BURST_MAX=4, RD_LATENCY=1) covers write,
// read, contention and urgent preemption; dut2 (BURST_MAX=4, RD_LATENCY=2)
// covers reset in the middle of a read. Each DUT has a small BRAM model.
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_frame_buffer_port_arbiter;
    import fb_arb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 16;
    localparam int BM = 4;

    logic clk_i    = 1'b0;
    logic resetn_i = 1'b0;
    always #5 clk_i = ~clk_i;

    frame_buffer_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();
    frame_buffer_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus2 ();

    frame_buffer_port_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_MAX(BM), .RD_LATENCY(1)
    ) dut1 (
        .clk_i    (clk_i),
        .resetn_i (resetn_i),
        .bus      (bus1.slave)
    );

    frame_buffer_port_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_MAX(BM), .RD_LATENCY(2)
    ) dut2 (
        .clk_i    (clk_i),
        .resetn_i (resetn_i),
        .bus      (bus2.slave)
    );

    // ---------------- BRAM models ----------------
    logic [DW-1:0] mem1 [32];
    logic [DW-1:0] rd1_q;
    always @(posedge clk_i) begin
        if (bus1.mem_we) mem1[bus1.mem_addr[4:0]] <= bus1.mem_wdata;
        rd1_q <= mem1[bus1.mem_addr[4:0]];
    end
    assign bus1.mem_rdata = rd1_q;

    logic [DW-1:0] mem2 [32];
    logic [DW-1:0] rd2_a, rd2_b;
    always @(posedge clk_i) begin
        if (bus2.mem_we) mem2[bus2.mem_addr[4:0]] <= bus2.mem_wdata;
        rd2_a <= mem2[bus2.mem_addr[4:0]];
        rd2_b <= rd2_a;
    end
    assign bus2.mem_rdata = rd2_b;

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic          wg;
        logic          rg;
        logic [1:0]    own;
        logic [AW-1:0] addr;
    } gexp_t;

    gexp_t         gq[$];
    logic [DW-1:0] rq1[$];
    logic [DW-1:0] rq2[$];
    int            n_exp_rd1 = 0;
    int            n_valid1  = 0;
    int            n_valid2  = 0;
    logic [1:0]    prev_sel  = OWNER_IDLE;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Grant monitor for dut1: one expectation per stimulus cycle.
    always @(negedge clk_i) begin : grant_mon
        gexp_t e;
        if (gq.size() > 0) begin
            e = gq.pop_front();
            check("wr_gnt", 32'(bus1.wr_gnt), 32'(e.wg));
            check("rd_gnt", 32'(bus1.rd_gnt), 32'(e.rg));
            check("mem_we", 32'(bus1.mem_we), 32'(e.wg));
            check("owner",  32'(bus1.owner),  32'(e.own));
            if (e.wg || e.rg) check("mem_addr", bus1.mem_addr, e.addr);
        end
    end

    // Read-data monitors: every valid must match the oldest outstanding read.
    always @(negedge clk_i) begin : rd1_mon
        if (bus1.rd_valid === 1'b1) begin
            n_valid1++;
            if (rq1.size() == 0) begin
                checks++; errors++;
                $display("FAIL rd_valid1: unexpected valid, data 0x%0h", bus1.rd_data);
            end else begin
                check("rd_data1", 32'(bus1.rd_data), 32'(rq1.pop_front()));
            end
        end
    end

    always @(negedge clk_i) begin : rd2_mon
        if (bus2.rd_valid === 1'b1) begin
            n_valid2++;
            if (rq2.size() == 0) begin
                checks++; errors++;
                $display("FAIL rd_valid2: unexpected valid, data 0x%0h", bus2.rd_data);
            end else begin
                check("rd_data2", 32'(bus2.rd_data), 32'(rq2.pop_front()));
            end
        end
    end

    // One dut1 cycle: drive inputs, record the expected grant ("W", "R", "-")
    // and, for a read, the data it must return.
    task automatic step(input logic wr, input logic rd, input logic urg,
                        input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic [AW-1:0] ra, input logic [DW-1:0] rexp,
                        input byte g);
        gexp_t e;
        bus1.wr_req    = wr;
        bus1.rd_req    = rd;
        bus1.rd_urgent = urg;
        bus1.wr_addr   = wa;
        bus1.wr_data   = wd;
        bus1.rd_addr   = ra;
        e.wg   = (g == "W");
        e.rg   = (g == "R");
        e.own  = prev_sel;
        e.addr = (g == "W") ? wa : ra;
        gq.push_back(e);
        if (g == "R") begin
            rq1.push_back(rexp);
            n_exp_rd1++;
        end
        prev_sel = (g == "W") ? OWNER_WR : (g == "R") ? OWNER_RD : OWNER_IDLE;
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle1();
        step(1'b0, 1'b0, 1'b0, '0, '0, '0, '0, "-");
    endtask

    // Contention pattern: both requests held; writes advance through
    // addresses 8+k, reads hold one address.
    task automatic contend(input string pat, input string urg_pat,
                           input logic [AW-1:0] ra, input logic [DW-1:0] rexp,
                           inout int k);
        for (int i = 0; i < pat.len(); i++) begin
            step(1'b1, 1'b1, (urg_pat[i] == "1"), AW'(8 + k), DW'(16'hB000 + k), ra, rexp, pat[i]);
            if (pat[i] == "W") k++;
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        int k;
        k = 0;
        {bus1.wr_req, bus1.rd_req, bus1.rd_urgent} = 3'b110;
        bus1.wr_addr = '0; bus1.wr_data = '0; bus1.rd_addr = '0;
        {bus2.wr_req, bus2.rd_req, bus2.rd_urgent} = 3'b000;
        bus2.wr_addr = '0; bus2.wr_data = '0; bus2.rd_addr = '0;

        // Reset: grants held low even with both requests up.
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check("rst owner",    32'(bus1.owner),    32'd0);
        check("rst wr_gnt",   32'(bus1.wr_gnt),   32'd0);
        check("rst rd_gnt",   32'(bus1.rd_gnt),   32'd0);
        check("rst mem_we",   32'(bus1.mem_we),   32'd0);
        check("rst rd_valid", 32'(bus1.rd_valid), 32'd0);
        @(posedge clk_i);
        #1;
        {bus1.wr_req, bus1.rd_req} = 2'b00;
        resetn_i = 1'b1;

        // Write only: 8 back-to-back grants.
        for (int i = 0; i < 8; i++)
            step(1'b1, 1'b0, 1'b0, AW'(i), DW'(16'hA000 + i), '0, '0, "W");
        idle1();
        for (int i = 0; i < 8; i++)
            check("bram word", 32'(mem1[i]), 32'(16'hA000 + i));

        // Read only: data returns one cycle after each grant.
        for (int i = 0; i < 8; i++)
            step(1'b0, 1'b1, 1'b0, '0, '0, AW'(i), DW'(16'hA000 + i), "R");
        idle1();
        idle1();

        // Contention without urgency.
        contend("WWWWRRRRWWWW", "000000000000", AW'(2), 16'hA002, k);
        idle1();

        // Urgent preemption at burst_cnt=2, then RRRRW with urgency held.
        contend("WWRRRRWRRRRW", "001111111111", AW'(5), 16'hA005, k);
        idle1();
        idle1();

        // Write then read the same address next cycle: new data returned.
        step(1'b1, 1'b0, 1'b0, AW'(3), 16'hC003, '0, '0, "W");
        step(1'b0, 1'b1, 1'b0, '0, '0, AW'(3), 16'hC003, "R");
        idle1();
        idle1();
        check("rd1 queue drained", 32'(rq1.size()), 32'd0);
        check("rd1 valid count",   32'(n_valid1),   32'(n_exp_rd1));

        // Reset mid-read on dut2 (RD_LATENCY=2).
        bus2.rd_req  = 1'b1;
        bus2.rd_addr = AW'(1);
        @(negedge clk_i);
        check("dut2 rd_gnt", 32'(bus2.rd_gnt), 32'd1);
        @(posedge clk_i);
        #1;
        resetn_i = 1'b0;
        {bus2.wr_req, bus2.rd_req} = 2'b11;
        bus2.wr_addr = AW'(1);
        bus2.wr_data = 16'hD001;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("dut2 rst rd_valid", 32'(bus2.rd_valid), 32'd0);
            check("dut2 rst wr_gnt",   32'(bus2.wr_gnt),   32'd0);
            check("dut2 rst rd_gnt",   32'(bus2.rd_gnt),   32'd0);
            check("dut2 rst owner",    32'(bus2.owner),    32'd0);
        end
        @(posedge clk_i);
        #1;
        resetn_i = 1'b1;
        @(negedge clk_i);
        check("dut2 post wr_gnt", 32'(bus2.wr_gnt), 32'd1);
        check("dut2 post rd_gnt", 32'(bus2.rd_gnt), 32'd0);
        check("dut2 post owner",  32'(bus2.owner),  32'd0);
        @(posedge clk_i);
        #1;
        bus2.wr_req = 1'b0;
        rq2.push_back(16'hD001);
        @(negedge clk_i);
        check("dut2 read rd_gnt", 32'(bus2.rd_gnt), 32'd1);
        check("dut2 read owner",  32'(bus2.owner),  32'd1);
        @(posedge clk_i);
        #1;
        bus2.rd_req = 1'b0;
        repeat (4) @(negedge clk_i);
        check("rd2 queue drained", 32'(rq2.size()), 32'd0);
        check("rd2 valid count",   32'(n_valid2),   32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_frame_buffer_port_arbiter
